buffer_write_arbiter: RTL and testbench



---
 rtl/buffer_write_arbiter.sv | 97 +++++++++
 tb/tb_buffer_write_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/buffer_write_arbiter.sv
// Round-robin arbiter sharing the write port of a byte-wide circular buffer
// among N_REQ producers, granting bursts and stalling while the buffer is full.
module buffer_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int BUF_DEPTH = 16,
    parameter int CNT_W     = 5,
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               buf_wr_en,
    output logic [7:0]         buf_wr_data,
    input  logic [CNT_W-1:0]   buf_count
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [IDX_W-1:0] g_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] next_ptr;
    logic             pick_valid;
    logic [BC_W-1:0]  burst_cnt;
    logic             wr_ok;
    logic             last_beat;

    // Scan downward so the lowest offset from rr_ptr overwrites and wins.
    always_comb begin
        int j;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

    assign wr_ok     = (state == BUSY) && req[g_idx] &&
                       (buf_count < CNT_W'(BUF_DEPTH)) && !reset;
    assign last_beat = req_last[g_idx] || (burst_cnt == BC_W'(MAX_BURST - 1));
    assign next_ptr  = (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;

    assign buf_wr_en   = wr_ok;
    assign ack         = wr_ok ? (N_REQ'(1) << g_idx) : '0;
    assign buf_wr_data = (state == BUSY) ? req_data[8*g_idx +: 8] : 8'h00;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            g_idx     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= BUSY;
                        busy      <= 1'b1;
                        g_idx     <= pick_idx;
                        grant     <= N_REQ'(1) << pick_idx;
                        burst_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (wr_ok) burst_cnt <= burst_cnt + 1'b1;
                    // A full buffer alone never releases: the owner keeps the port.
                    if (!req[g_idx] || (wr_ok && last_beat)) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Directed, table-driven bench for buffer_write_arbiter with hand-computed
// expected outputs per cycle plus multi-cycle corner-case sequences.
module tb_buffer_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic        buf_wr_en;
    logic [7:0]  buf_wr_data;
    logic [4:0]  buf_count;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  last;
        logic [4:0]  cnt;
        logic [3:0]  e_ack;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic        e_wr;
        logic [7:0]  e_wdata;
    } vec_t;

    vec_t tbl[$];

    buffer_write_arbiter #(
        .N_REQ(4), .BUF_DEPTH(16), .CNT_W(5), .MAX_BURST(8)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .req_last(req_last), .ack(ack), .grant(grant), .busy(busy),
        .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(logic rst, logic [3:0] rq, logic [31:0] d,
                               logic [3:0] l, logic [4:0] c, logic [3:0] ea,
                               logic [3:0] eg, logic eb, logic ew, logic [7:0] ed);
        vec_t r;
        r.rst = rst; r.req = rq; r.data = d; r.last = l; r.cnt = c;
        r.e_ack = ea; r.e_grant = eg; r.e_busy = eb; r.e_wr = ew; r.e_wdata = ed;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    // Drive on the falling edge, compare mid-low-phase, before the next rising edge.
    task automatic run_vec(input vec_t t, input string tag);
        @(negedge clk);
        reset = t.rst; req = t.req; req_data = t.data; req_last = t.last; buf_count = t.cnt;
        #1;
        check({tag, ".ack"},   32'(ack),         32'(t.e_ack));
        check({tag, ".grant"}, 32'(grant),       32'(t.e_grant));
        check({tag, ".busy"},  32'(busy),        32'(t.e_busy));
        check({tag, ".wr_en"}, 32'(buf_wr_en),   32'(t.e_wr));
        check({tag, ".wdata"}, 32'(buf_wr_data), 32'(t.e_wdata));
    endtask

    initial begin
        logic [3:0]  oh;
        logic [7:0]  bt;
        logic [31:0] d;
        int          order[3];

        reset = 1'b1; req = '0; req_data = '0; req_last = '0; buf_count = '0;
        repeat (2) @(posedge clk);

        // Reset and idle.
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        // Requester 2 sends A1, A2, A3 (last).
        tbl.push_back(v(0, 4'b0100, 32'h00A1_0000, 4'b0000, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(v(0, 4'b0100, 32'h00A1_0000, 4'b0000, 0, 4'b0100, 4'b0100, 1, 1, 8'hA1));
        tbl.push_back(v(0, 4'b0100, 32'h00A2_0000, 4'b0000, 0, 4'b0100, 4'b0100, 1, 1, 8'hA2));
        tbl.push_back(v(0, 4'b0100, 32'h00A3_0000, 4'b0100, 0, 4'b0100, 4'b0100, 1, 1, 8'hA3));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        // Reset to bring rr_ptr back to 0, then 0,1,3 contend with single-byte packets.
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        order = '{0, 1, 3};
        d = 32'hB300_B1B0;
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int k = 0; k < 3; k++) begin
                oh = 4'(1) << order[k];
                bt = d[8*order[k] +: 8];
                tbl.push_back(v(0, 4'b1011, d, 4'b1011, 0, 0, 0, 0, 0, 8'h00));
                tbl.push_back(v(0, 4'b1011, d, 4'b1011, 0, oh, oh, 1, 1, bt));
            end
        end
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Requester 1 streams 0x10..0x1B while 2 waits; burst capped at 8 bytes.
        for (int b = 0; b < 12; b++) begin
            bt = 8'h10 + 8'(b);
            d  = {8'h00, 8'hC2, bt, 8'h00};
            if (b == 0)
                run_vec(v(0, 4'b0110, d, 4'b0100, 0, 0, 0, 0, 0, 8'h00), "burst_arb");
            if (b == 8) begin
                run_vec(v(0, 4'b0110, d, 4'b0100, 0, 0, 0, 0, 0, 8'h00), "burst_gap");
                run_vec(v(0, 4'b0110, d, 4'b0100, 0, 4'b0100, 4'b0100, 1, 1, 8'hC2), "burst_req2");
                run_vec(v(0, 4'b0010, d, 4'b0000, 0, 0, 0, 0, 0, 8'h00), "burst_regap");
            end
            run_vec(v(0, (b < 8) ? 4'b0110 : 4'b0010, d, {3'b010, 1'b0} & 4'b0100 | ((b == 11) ? 4'b0010 : 4'b0000),
                      0, 4'b0010, 4'b0010, 1, 1, bt), $sformatf("burst_b%0d", b));
        end
        run_vec(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00), "burst_end");

        // Buffer full for 4 cycles: grant held, no write until count drops to 15.
        run_vec(v(0, 4'b0001, 32'h0000_0055, 4'b0001, 5'd16, 0, 0, 0, 0, 8'h00), "full_arb");
        for (int i = 0; i < 4; i++)
            run_vec(v(0, 4'b0001, 32'h0000_0055, 4'b0001, 5'd16, 0, 4'b0001, 1, 0, 8'h55),
                    $sformatf("full_stall%0d", i));
        run_vec(v(0, 4'b0001, 32'h0000_0055, 4'b0001, 5'd15, 4'b0001, 4'b0001, 1, 1, 8'h55), "full_resume");
        run_vec(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00), "full_end");

        // Reset during the second byte of a 3-byte burst from requester 2.
        run_vec(v(0, 4'b0100, 32'h00D1_0000, 0, 0, 0, 0, 0, 0, 8'h00), "rst_arb");
        run_vec(v(0, 4'b0100, 32'h00D1_0000, 0, 0, 4'b0100, 4'b0100, 1, 1, 8'hD1), "rst_b0");
        run_vec(v(1, 4'b0100, 32'h00D2_0000, 0, 0, 0, 4'b0100, 1, 0, 8'hD2), "rst_b1");
        // rr_ptr back at 0: requester 0 must win over 3.
        run_vec(v(0, 4'b1001, 32'h3300_0030, 4'b1001, 0, 0, 0, 0, 0, 8'h00), "rst_idle");
        run_vec(v(0, 4'b1001, 32'h3300_0030, 4'b1001, 0, 4'b0001, 4'b0001, 1, 1, 8'h30), "rst_rr0");
        run_vec(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00), "rst_end");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
